// File: rtl/task_fetch_frontend.sv
// task_fetch_frontend
//   Core-side initiator of the task-read/finish protocol. Each lane (one per core) takes a dequeue
//   request, issues m_arvalid/m_araddr to the serializer, and captures the one-cycle response. It then
//   offers the task to its core (valid/ready), waits for core_done, and queues a finish notification.
//   Finish notifications from all lanes share one round-robin output stream, one per cycle.
// Ports
//   clk, rstn                      clock, synchronous active-low reset
//   core_req/core_ttype            per-core dequeue request and task type (sampled in IDLE)
//   core_task_valid/ready          per-core task handoff; core_task/core_cq_slot hold the task
//   core_done                      per-core completion pulse (valid only in RUN)
//   m_arvalid/m_araddr             per-core read request to the serializer
//   m_rvalid/m_rdata/m_cq_slot     serializer response (one-hot strobe, shared data)
//   finished_task_valid/core       finish notification stream
//   busy_lanes                     registered count of non-IDLE lanes
//   n_dispatched/n_finished        wrapping 32-bit event counters
//   proto_err                      sticky protocol-error flag

package task_fetch_pkg;
    typedef logic [3:0] task_type_t;
    typedef struct packed {
        logic [3:0]  ttype;
        logic [7:0]  hint;
        logic [31:0] args;
    } task_t;
    typedef logic [7:0] cq_slice_slot_t;
endpackage

module task_fetch_frontend
    import task_fetch_pkg::*;
#(
    parameter int unsigned NUM_CORES = 10,
    parameter int unsigned TILE_ID   = 0,
    localparam int unsigned CORE_W   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
    localparam int unsigned BUSY_W   = $clog2(NUM_CORES + 1)
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic [NUM_CORES-1:0]             core_req,
    input  task_type_t [NUM_CORES-1:0]       core_ttype,
    output logic [NUM_CORES-1:0]             core_task_valid,
    input  logic [NUM_CORES-1:0]             core_task_ready,
    output task_t [NUM_CORES-1:0]            core_task,
    output cq_slice_slot_t [NUM_CORES-1:0]   core_cq_slot,
    input  logic [NUM_CORES-1:0]             core_done,
    output logic [NUM_CORES-1:0]             m_arvalid,
    output task_type_t [NUM_CORES-1:0]       m_araddr,
    input  logic [NUM_CORES-1:0]             m_rvalid,
    input  task_t                            m_rdata,
    input  cq_slice_slot_t                   m_cq_slot,
    output logic                             finished_task_valid,
    output logic [CORE_W-1:0]                finished_task_core,
    output logic [BUSY_W-1:0]                busy_lanes,
    output logic [31:0]                      n_dispatched,
    output logic [31:0]                      n_finished,
    output logic                             proto_err
);

    // TILE_ID is debug-only; keep it within a 16-bit tile index space.
    if (TILE_ID > 32'hFFFF) begin : g_bad_tile_id
        $error("task_fetch_frontend: TILE_ID out of range");
    end

    typedef enum logic [2:0] {StIdle, StReq, StHold, StRun, StFin} lane_state_t;

    lane_state_t                    state_q [NUM_CORES];
    lane_state_t                    state_d [NUM_CORES];
    task_type_t [NUM_CORES-1:0]     ttype_q;
    task_t [NUM_CORES-1:0]          task_q;
    cq_slice_slot_t [NUM_CORES-1:0] slot_q;
    logic [CORE_W-1:0]              rr_q;
    logic                           fin_valid_q;
    logic [CORE_W-1:0]              fin_core_q;
    logic [BUSY_W-1:0]              busy_q;
    logic [31:0]                    n_disp_q;
    logic [31:0]                    n_fin_q;
    logic                           err_q;

    logic                 rsp_multi;
    logic [NUM_CORES-1:0] rsp_hit;
    logic [NUM_CORES-1:0] dispatch;
    logic [NUM_CORES-1:0] fin_req;
    logic                 grant_valid;
    logic [CORE_W-1:0]    grant_idx;
    logic                 err_d;
    logic [BUSY_W-1:0]    busy_d;
    logic [31:0]          n_disp_inc;
    int                   idx;

    always_comb begin
        // A multi-hot strobe cannot be attributed to one lane, so every bit is dropped.
        rsp_multi   = $countones(m_rvalid) > 1;
        err_d       = rsp_multi;
        rsp_hit     = '0;
        dispatch    = '0;
        fin_req     = '0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        busy_d      = '0;
        idx         = 0;
        for (int i = 0; i < int'(NUM_CORES); i++) begin
            rsp_hit[i]  = m_rvalid[i] && !rsp_multi && (state_q[i] == StReq);
            dispatch[i] = (state_q[i] == StHold) && core_task_ready[i];
            fin_req[i]  = (state_q[i] == StFin);
            if (m_rvalid[i] && (state_q[i] != StReq)) err_d = 1'b1;
            if (core_done[i] && (state_q[i] != StRun)) err_d = 1'b1;
        end
        // Round-robin: first FIN lane at or after the pointer wins.
        for (int k = 0; k < int'(NUM_CORES); k++) begin
            idx = (int'(rr_q) + k) % int'(NUM_CORES);
            if (!grant_valid && fin_req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = CORE_W'(idx);
            end
        end
        for (int i = 0; i < int'(NUM_CORES); i++) begin
            state_d[i] = state_q[i];
            unique case (state_q[i])
                StIdle: if (core_req[i]) state_d[i] = StReq;
                StReq:  if (rsp_hit[i]) state_d[i] = StHold;
                StHold: if (core_task_ready[i]) state_d[i] = StRun;
                StRun:  if (core_done[i]) state_d[i] = StFin;
                StFin:  if (grant_valid && (grant_idx == CORE_W'(i))) state_d[i] = StIdle;
                default: state_d[i] = StIdle;
            endcase
            if (state_d[i] != StIdle) busy_d = busy_d + BUSY_W'(1);
        end
        n_disp_inc = 32'($countones(dispatch));
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < int'(NUM_CORES); i++) state_q[i] <= StIdle;
            ttype_q     <= '0;
            task_q      <= '0;
            slot_q      <= '0;
            rr_q        <= '0;
            fin_valid_q <= 1'b0;
            fin_core_q  <= '0;
            busy_q      <= '0;
            n_disp_q    <= '0;
            n_fin_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NUM_CORES); i++) begin
                state_q[i] <= state_d[i];
                if ((state_q[i] == StIdle) && core_req[i]) ttype_q[i] <= core_ttype[i];
                if (rsp_hit[i]) begin
                    task_q[i] <= m_rdata;
                    slot_q[i] <= m_cq_slot;
                end
            end
            fin_valid_q <= grant_valid;
            if (grant_valid) begin
                fin_core_q <= grant_idx;
                rr_q       <= (grant_idx == CORE_W'(NUM_CORES - 1)) ? '0 : grant_idx + CORE_W'(1);
                n_fin_q    <= n_fin_q + 32'd1;
            end
            n_disp_q <= n_disp_q + n_disp_inc;
            busy_q   <= busy_d;
            if (err_d) err_q <= 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NUM_CORES); i++) begin
            core_task_valid[i] = (state_q[i] == StHold);
            m_arvalid[i]       = (state_q[i] == StReq);
        end
    end

    assign m_araddr            = ttype_q;
    assign core_task           = task_q;
    assign core_cq_slot        = slot_q;
    assign finished_task_valid = fin_valid_q;
    assign finished_task_core  = fin_core_q;
    assign busy_lanes          = busy_q;
    assign n_dispatched        = n_disp_q;
    assign n_finished          = n_fin_q;
    assign proto_err           = err_q;

endmodule
